// File: rtl/vga_timing_generator.sv
// 640x480@60 Hz VGA raster timing: pixel-rate divider, h/v counters, registered sync/coordinate strobes.
// Optional macro VGA_TIMING_SECOND_TICK_EN adds a frame counter and the second_tick output.
module vga_timing_generator #(
   parameter int CLK_DIV           = 2,
   parameter int H_VISIBLE         = 640,
   parameter int H_FRONT           = 16,
   parameter int H_SYNC            = 96,
   parameter int H_BACK            = 48,
   parameter int V_VISIBLE         = 480,
   parameter int V_FRONT           = 10,
   parameter int V_SYNC            = 2,
   parameter int V_BACK            = 33,
   parameter int FRAMES_PER_SECOND = 60
) (
   input  logic clk,
   input  logic reset_n,
   output int   col,
   output int   row,
   output logic hsync,
   output logic vsync,
   output logic visible,
   output logic pixel_en,
   output logic frame_start
`ifdef VGA_TIMING_SECOND_TICK_EN
   ,output logic second_tick
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
   localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
   localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
   localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
   localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

   if ((CLK_DIV < 1) || (FRAMES_PER_SECOND < 1)) begin : g_bad_param
      $error("vga_timing_generator: CLK_DIV and FRAMES_PER_SECOND must be at least 1");
   end

   logic [DW-1:0] div_cnt_r;
   logic [HW-1:0] h_cnt_r;
   logic [VW-1:0] v_cnt_r;
   logic [DW-1:0] div_nxt_s;
   logic [HW-1:0] h_nxt_s;
   logic [VW-1:0] v_nxt_s;
   logic          tick_s;
   logic          visible_s;
   logic          hsync_s;
   logic          vsync_s;
   logic          frame_start_s;

   // Next-state counters; outputs are derived from these so they move on the same edge as the counters.
   always_comb begin
      tick_s    = (div_cnt_r == DIV_LAST);
      div_nxt_s = div_cnt_r;
      h_nxt_s   = h_cnt_r;
      v_nxt_s   = v_cnt_r;
      if (tick_s) begin
         div_nxt_s = {DW{1'b0}};
         if (h_cnt_r == H_LAST) begin
            h_nxt_s = {HW{1'b0}};
            if (v_cnt_r == V_LAST) begin
               v_nxt_s = {VW{1'b0}};
            end else begin
               v_nxt_s = v_cnt_r + 1'b1;
            end
         end else begin
            h_nxt_s = h_cnt_r + 1'b1;
         end
      end else begin
         div_nxt_s = div_cnt_r + 1'b1;
      end
      visible_s     = (h_nxt_s < H_VIS) && (v_nxt_s < V_VIS);
      hsync_s       = !((h_nxt_s >= HS_START) && (h_nxt_s < HS_END));
      vsync_s       = !((v_nxt_s >= VS_START) && (v_nxt_s < VS_END));
      frame_start_s = tick_s && (h_nxt_s == {HW{1'b0}}) && (v_nxt_s == {VW{1'b0}});
   end

   // Counter state and aligned output registers; reset parks the counters at the last pixel of a frame.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         div_cnt_r   <= {DW{1'b0}};
         h_cnt_r     <= H_LAST;
         v_cnt_r     <= V_LAST;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         visible     <= 1'b0;
         col         <= 32'd0;
         row         <= 32'd0;
         pixel_en    <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         div_cnt_r   <= div_nxt_s;
         h_cnt_r     <= h_nxt_s;
         v_cnt_r     <= v_nxt_s;
         hsync       <= hsync_s;
         vsync       <= vsync_s;
         visible     <= visible_s;
         col         <= visible_s ? 32'(h_nxt_s) : 32'd0;
         row         <= visible_s ? 32'(v_nxt_s) : 32'd0;
         pixel_en    <= tick_s;
         frame_start <= frame_start_s;
      end
   end

`ifdef VGA_TIMING_SECOND_TICK_EN
   localparam int FW = (FRAMES_PER_SECOND > 1) ? $clog2(FRAMES_PER_SECOND) : 1;
   localparam logic [FW-1:0] F_LAST = FW'(FRAMES_PER_SECOND - 1);

   logic [FW-1:0] fcnt_r;

   // Frame counter; second_tick fires on the frame_start that wraps it.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         fcnt_r      <= {FW{1'b0}};
         second_tick <= 1'b0;
      end else begin
         second_tick <= frame_start_s && (fcnt_r == F_LAST);
         if (frame_start_s) begin
            if (fcnt_r == F_LAST) begin
               fcnt_r <= {FW{1'b0}};
            end else begin
               fcnt_r <= fcnt_r + 1'b1;
            end
         end else begin
            fcnt_r <= fcnt_r;
         end
      end
   end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Bench for vga_timing_generator: two reduced-size instances (CLK_DIV=2 and CLK_DIV=1) checked every clk
// against an elapsed-clock arithmetic model, plus targeted timing measurements and random resets.
module tb_vga_timing_generator;

   localparam longint HV = 16, HF = 4, HS = 6, HB = 4;
   localparam longint VV = 10, VF = 2, VS = 2, VB = 3;
   localparam longint HT = HV + HF + HS + HB;
   localparam longint VT = VV + VF + VS + VB;
   localparam longint TOT = HT * VT;
   localparam longint FPS = 3;
   localparam longint DIV0 = 2, DIV1 = 1;

   typedef struct packed {
      logic [31:0] col;
      logic [31:0] row;
      logic        hsync;
      logic        vsync;
      logic        visible;
      logic        pixel_en;
      logic        frame_start;
      logic        second_tick;
   } vga_out_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   col0, row0, col1, row1;
   logic hs0, vs0, vis0, pe0, fs0, st0;
   logic hs1, vs1, vis1, pe1, fs1, st1;
   vga_out_t act_s [2];
   longint e = 0;
   int assert_cnt = 0;
   int fail_cnt = 0;

   always #5 clk = ~clk;

   vga_timing_generator #(.CLK_DIV(2), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .FRAMES_PER_SECOND(3)) dut0 (
      .clk(clk), .reset_n(reset_n), .col(col0), .row(row0), .hsync(hs0), .vsync(vs0),
      .visible(vis0), .pixel_en(pe0), .frame_start(fs0)
`ifdef VGA_TIMING_SECOND_TICK_EN
      , .second_tick(st0)
`endif
   );

   vga_timing_generator #(.CLK_DIV(1), .H_VISIBLE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
      .V_VISIBLE(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .FRAMES_PER_SECOND(3)) dut1 (
      .clk(clk), .reset_n(reset_n), .col(col1), .row(row1), .hsync(hs1), .vsync(vs1),
      .visible(vis1), .pixel_en(pe1), .frame_start(fs1)
`ifdef VGA_TIMING_SECOND_TICK_EN
      , .second_tick(st1)
`endif
   );

`ifndef VGA_TIMING_SECOND_TICK_EN
   assign st0 = 1'b0;
   assign st1 = 1'b0;
`endif

   assign act_s[0] = {col0, row0, hs0, vs0, vis0, pe0, fs0, st0};
   assign act_s[1] = {col1, row1, hs1, vs1, vis1, pe1, fs1, st1};

   // Expected outputs after ev clk edges since reset release: pixel n = ev/div, counters start one pixel before (0,0).
   function automatic vga_out_t exp_at(longint ev, longint div);
      longint n, idx, h, v;
      vga_out_t r;
      n   = ev / div;
      idx = (n + TOT - 1) % TOT;
      h   = idx % HT;
      v   = idx / HT;
      r.visible     = (h < HV) && (v < VV);
      r.col         = r.visible ? 32'(h) : 32'd0;
      r.row         = r.visible ? 32'(v) : 32'd0;
      r.hsync       = !((h >= HV + HF) && (h < HV + HF + HS));
      r.vsync       = !((v >= VV + VF) && (v < VV + VF + VS));
      r.pixel_en    = (ev > 0) && (ev % div == 0);
      r.frame_start = r.pixel_en && (idx == 0);
`ifdef VGA_TIMING_SECOND_TICK_EN
      r.second_tick = r.frame_start && (((n - 1) / TOT + 1) % FPS == 0);
`else
      r.second_tick = 1'b0;
`endif
      return r;
   endfunction

   task automatic advance();
      @(posedge clk);
      if (!reset_n) e = 0;
      else e = e + 1;
      #1;
   endtask

   task automatic test_reset();
      vga_out_t x;
      reset_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         advance();
         for (int d = 0; d < 2; d++) begin
            x = exp_at(e, (d == 0) ? DIV0 : DIV1);
            assert_cnt++;
            if (act_s[d] !== x) begin
               fail_cnt++;
               $display("FAIL reset dut%0d cyc=%0d: got %p, expected %p", d, c, act_s[d], x);
            end
         end
      end
   endtask

   task automatic test_first_frame();
      vga_out_t x;
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         advance();
         for (int d = 0; d < 2; d++) begin
            x = exp_at(e, (d == 0) ? DIV0 : DIV1);
            assert_cnt++;
            if (act_s[d] !== x) begin
               fail_cnt++;
               $display("FAIL first_frame dut%0d e=%0d: got %p, expected %p", d, e, act_s[d], x);
            end
         end
         if (e == 2) begin
            assert_cnt++;
            if ({fs0, pe0, vis0, col0, row0} !== {1'b1, 1'b1, 1'b1, 32'd0, 32'd0}) begin
               fail_cnt++;
               $display("FAIL first_pixel: got fs=%b pe=%b vis=%b col=%0d row=%0d, expected 1 1 1 0 0",
                        fs0, pe0, vis0, col0, row0);
            end
         end
         if (e == 4) begin
            assert_cnt++;
            if (col0 !== 1) begin
               fail_cnt++;
               $display("FAIL second_pixel_col: got %0d, expected 1", col0);
            end
         end
      end
   endtask

   task automatic test_hsync_line();
      vga_out_t x;
      longint falls[$];
      longint rise_e = -1;
      logic prev = hs1;
      for (int c = 0; c < 3 * HT; c++) begin
         advance();
         for (int d = 0; d < 2; d++) begin
            x = exp_at(e, (d == 0) ? DIV0 : DIV1);
            assert_cnt++;
            if (act_s[d] !== x) begin
               fail_cnt++;
               $display("FAIL hsync_line dut%0d e=%0d: got %p, expected %p", d, e, act_s[d], x);
            end
         end
         if (prev && !hs1) falls.push_back(e);
         if (!prev && hs1 && falls.size() == 1) rise_e = e;
         prev = hs1;
      end
      assert_cnt++;
      if (falls.size() < 2 || rise_e < 0) begin
         fail_cnt++;
         $display("FAIL hsync_edges: got %0d falls, rise=%0d, expected >=2 falls and a rise", falls.size(), rise_e);
      end else begin
         assert_cnt++;
         if (rise_e - falls[0] != HS) begin
            fail_cnt++;
            $display("FAIL hsync_width: got %0d clks, expected %0d", rise_e - falls[0], HS);
         end
         assert_cnt++;
         if (falls[1] - falls[0] != HT) begin
            fail_cnt++;
            $display("FAIL line_period: got %0d clks, expected %0d", falls[1] - falls[0], HT);
         end
      end
   endtask

   task automatic test_frame();
      vga_out_t x;
      longint fs_t[$];
      longint vfall = -1, vrise = -1;
      logic prev = vs0;
      for (int c = 0; c < 2 * TOT * DIV0 + 40; c++) begin
         advance();
         for (int d = 0; d < 2; d++) begin
            x = exp_at(e, (d == 0) ? DIV0 : DIV1);
            assert_cnt++;
            if (act_s[d] !== x) begin
               fail_cnt++;
               $display("FAIL frame dut%0d e=%0d: got %p, expected %p", d, e, act_s[d], x);
            end
         end
         if (fs0) fs_t.push_back(e);
         if (prev && !vs0 && vfall < 0) vfall = e;
         if (!prev && vs0 && vfall >= 0 && vrise < 0) vrise = e;
         prev = vs0;
      end
      assert_cnt++;
      if (fs_t.size() < 2) begin
         fail_cnt++;
         $display("FAIL frame_starts: got %0d, expected >=2", fs_t.size());
      end else if (fs_t[1] - fs_t[0] != TOT * DIV0) begin
         fail_cnt++;
         $display("FAIL frame_period: got %0d clks, expected %0d", fs_t[1] - fs_t[0], TOT * DIV0);
      end
      assert_cnt++;
      if (vfall < 0 || vrise < 0 || vrise - vfall != VS * HT * DIV0) begin
         fail_cnt++;
         $display("FAIL vsync_width: got fall=%0d rise=%0d, expected width %0d", vfall, vrise, VS * HT * DIV0);
      end
   endtask

   task automatic test_mid_frame_reset();
      vga_out_t x;
      bit found = 1'b0;
      for (int c = 0; c < 2 * TOT * DIV0 && !found; c++) begin
         advance();
         for (int d = 0; d < 2; d++) begin
            x = exp_at(e, (d == 0) ? DIV0 : DIV1);
            assert_cnt++;
            if (act_s[d] !== x) begin
               fail_cnt++;
               $display("FAIL mid_reset_run dut%0d e=%0d: got %p, expected %p", d, e, act_s[d], x);
            end
         end
         if (col0 == HV / 2 && row0 == VV / 2) found = 1'b1;
      end
      assert_cnt++;
      if (!found) begin
         fail_cnt++;
         $display("FAIL mid_reset_target: got no pixel (%0d,%0d), expected it within budget", HV / 2, VV / 2);
      end
      reset_n = 1'b0;
      advance();
      assert_cnt++;
      if ({hs0, vs0, vis0, col0, row0, pe0, fs0} !== {1'b1, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0}) begin
         fail_cnt++;
         $display("FAIL mid_reset_values: got hs=%b vs=%b vis=%b col=%0d row=%0d pe=%b fs=%b, expected 1 1 0 0 0 0 0",
                  hs0, vs0, vis0, col0, row0, pe0, fs0);
      end
      reset_n = 1'b1;
      advance();
      assert_cnt++;
      if ({fs0, fs1} !== 2'b01) begin
         fail_cnt++;
         $display("FAIL restart_edge1: got fs0=%b fs1=%b, expected 0 1", fs0, fs1);
      end
      advance();
      assert_cnt++;
      if ({fs0, col0, row0, vis0} !== {1'b1, 32'd0, 32'd0, 1'b1}) begin
         fail_cnt++;
         $display("FAIL restart_edge2: got fs0=%b col=%0d row=%0d vis=%b, expected 1 0 0 1", fs0, col0, row0, vis0);
      end
   endtask

   task automatic test_random_resets();
      vga_out_t x;
      int run_len, rst_len;
      for (int k = 0; k < 8; k++) begin
         run_len = $urandom_range(2500, 50);
         rst_len = $urandom_range(3, 1);
         reset_n = 1'b1;
         for (int c = 0; c < run_len + rst_len; c++) begin
            if (c == run_len) reset_n = 1'b0;
            advance();
            for (int d = 0; d < 2; d++) begin
               x = exp_at(e, (d == 0) ? DIV0 : DIV1);
               assert_cnt++;
               if (act_s[d] !== x) begin
                  fail_cnt++;
                  $display("FAIL random dut%0d k=%0d e=%0d: got %p, expected %p", d, k, e, act_s[d], x);
               end
            end
         end
      end
      reset_n = 1'b1;
   endtask

   task automatic test_second_tick();
      vga_out_t x;
      int n0 = 0, n1 = 0;
      longint cycles = 3 * FPS * TOT * DIV0 + 10;
      longint exp0, exp1;
      reset_n = 1'b0;
      advance();
      reset_n = 1'b1;
      for (longint c = 0; c < cycles; c++) begin
         advance();
         for (int d = 0; d < 2; d++) begin
            x = exp_at(e, (d == 0) ? DIV0 : DIV1);
            assert_cnt++;
            if (act_s[d] !== x) begin
               fail_cnt++;
               $display("FAIL second_tick_run dut%0d e=%0d: got %p, expected %p", d, e, act_s[d], x);
            end
         end
         if (st0) n0++;
         if (st1) n1++;
      end
`ifdef VGA_TIMING_SECOND_TICK_EN
      exp0 = (((cycles / DIV0) - 1) / TOT + 1) / FPS;
      exp1 = (((cycles / DIV1) - 1) / TOT + 1) / FPS;
`else
      exp0 = 0;
      exp1 = 0;
`endif
      assert_cnt++;
      if (n0 != exp0 || n1 != exp1) begin
         fail_cnt++;
         $display("FAIL second_tick_count: got %0d/%0d, expected %0d/%0d", n0, n1, exp0, exp1);
      end
   endtask

   initial begin
      test_reset();
      test_first_frame();
      test_hsync_line();
      test_frame();
      test_mid_frame_reset();
      test_random_resets();
      test_second_tick();
      $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
      $finish;
   end

endmodule
